// File: rtl/reg_file_arb_pkg.sv
// reg_file_arb_pkg: shared constants, typedefs and address range check for the register-file arbiter
package reg_file_arb_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_REG_NUMBER = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W = $clog2(DEF_REG_NUMBER) + 1;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  function automatic logic addr_in_range(input int addr, input int limit);
    return addr < limit;
  endfunction
endpackage

// File: rtl/reg_file_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; priority starts at ptr and wraps, ptr moves past each winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      ptr
);
  logic [PW-1:0] nxt;
  logic found;
  int idx;
  always_comb begin
    grant = '0;
    nxt = ptr;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
        nxt = (idx == NUM_REQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= nxt;
  end
endmodule

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: shares the register file's read and write ports among NUM_REQ requesters
module reg_file_arbiter
  import reg_file_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_NUMBER = DEF_REG_NUMBER,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W = $clog2(REG_NUMBER) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            rd_valid,
  output logic [NUM_REQ-1:0]            rd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     rd_addr,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  input  logic [NUM_REQ-1:0]            wr_valid,
  output logic [NUM_REQ-1:0]            wr_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_ack,
  output logic                          wr_err,
  output logic                          rf_en_r,
  output logic                          rf_en_w,
  output logic [ADDR_W-1:0]             rf_sel_r,
  output logic [ADDR_W-1:0]             rf_sel_w,
  output logic [DATA_WIDTH-1:0]         rf_data_in,
  input  logic [DATA_WIDTH-1:0]         rf_data_out
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] rd_ptr_unused, wr_ptr_unused;
  logic [ADDR_W-1:0] rd_sel, wr_sel;
  logic [DATA_WIDTH-1:0] wr_dsel, byp_data;
  logic [NUM_REQ-1:0] rd_p1;
  logic rd_acc, wr_acc, rd_ok, wr_ok, rd_p1_err, byp_hit;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk(clk), .rst_n(rst_n), .req(rst_n ? rd_valid : '0), .advance(rd_acc),
    .grant(rd_ready), .ptr(rd_ptr_unused)
  );
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk(clk), .rst_n(rst_n), .req(rst_n ? wr_valid : '0), .advance(wr_acc),
    .grant(wr_ready), .ptr(wr_ptr_unused)
  );
  always_comb begin
    rd_sel = '0;
    wr_sel = '0;
    wr_dsel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_sel |= rd_ready[i] ? rd_addr[i*ADDR_W +: ADDR_W] : '0;
      wr_sel |= wr_ready[i] ? wr_addr[i*ADDR_W +: ADDR_W] : '0;
      wr_dsel |= wr_ready[i] ? wr_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end
  assign rd_acc = |rd_ready;
  assign wr_acc = |wr_ready;
  assign rd_ok = addr_in_range(int'(rd_sel), REG_NUMBER);
  assign wr_ok = addr_in_range(int'(wr_sel), REG_NUMBER);
  // The register file returns the pre-write value on a same-cycle read/write, so forward the write data
  assign rsp_data = (|rsp_valid && !rsp_err) ? (byp_hit ? byp_data : rf_data_out) : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_en_r <= 1'b0;
      rf_en_w <= 1'b0;
      rf_sel_r <= '0;
      rf_sel_w <= '0;
      rf_data_in <= '0;
      rd_p1 <= '0;
      rd_p1_err <= 1'b0;
      rsp_valid <= '0;
      rsp_err <= 1'b0;
      wr_ack <= '0;
      wr_err <= 1'b0;
      byp_hit <= 1'b0;
      byp_data <= '0;
    end else begin
      rf_en_r <= rd_acc && rd_ok;
      rf_sel_r <= (rd_acc && rd_ok) ? rd_sel : rf_sel_r;
      rd_p1 <= rd_ready;
      rd_p1_err <= rd_acc && !rd_ok;
      rf_en_w <= wr_acc && wr_ok;
      rf_sel_w <= (wr_acc && wr_ok) ? wr_sel : rf_sel_w;
      rf_data_in <= (wr_acc && wr_ok) ? wr_dsel : rf_data_in;
      wr_ack <= wr_ready;
      wr_err <= wr_acc && !wr_ok;
      rsp_valid <= rd_p1;
      rsp_err <= rd_p1_err;
      byp_hit <= rf_en_r && rf_en_w && (rf_sel_r == rf_sel_w);
      byp_data <= rf_data_in;
    end
  end
endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter: directed stimulus with a queued scoreboard checked by a separate output monitor
module tb_reg_file_arbiter;
  localparam int N = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  typedef struct {
    int idx;
    logic [DW-1:0] data;
    logic err;
    logic en;
    logic [AW-1:0] sel;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] rd_valid = '0, rd_ready, rsp_valid, wr_valid = '0, wr_ready, wr_ack;
  logic [N*AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [DW-1:0] rsp_data, rf_data_in, rf_data_out;
  logic rsp_err, wr_err, rf_en_r, rf_en_w;
  logic [AW-1:0] rf_sel_r, rf_sel_w;
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] vals [4];
  exp_t rd_q[$], wr_q[$];
  exp_t e;
  int cyc_n = 0;
  int n_pass = 0;
  int n_tot = 0;
  reg_file_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rf_en_r(rf_en_r), .rf_en_w(rf_en_w), .rf_sel_r(rf_sel_r), .rf_sel_w(rf_sel_w),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rf_data_out = '0;
  end
  // Register-file model: registered read, read-before-write on the same address
  always @(posedge clk) begin
    if (rf_en_r) rf_data_out <= mem[rf_sel_r];
    if (rf_en_w) mem[rf_sel_w] <= rf_data_in;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_rd(input int g, input logic [AW-1:0] a);
    rd_valid[g] = 1'b1;
    rd_addr[g*AW +: AW] = a;
  endtask
  task automatic set_wr(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid[g] = 1'b1;
    wr_addr[g*AW +: AW] = a;
    wr_data[g*DW +: DW] = d;
  endtask
  task automatic exp_rd(input int g, input logic [DW-1:0] d, input logic er);
    rd_q.push_back('{g, d, er, 1'b0, '0, cyc_n + 2});
  endtask
  task automatic exp_wr(input int g, input logic er, input logic en, input logic [AW-1:0] s, input logic [DW-1:0] d);
    wr_q.push_back('{g, d, er, en, s, cyc_n + 1});
  endtask
  always @(negedge clk) begin
    if (|rsp_valid) begin
      if (rd_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      else begin
        e = rd_q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_cycle", 64'(cyc_n), 64'(e.cyc));
      end
    end
    if (|wr_ack) begin
      if (wr_q.size() == 0) chk("wr_ack_unexpected", 64'(wr_ack), 64'(0));
      else begin
        e = wr_q.pop_front();
        chk("wr_ack", 64'(wr_ack), 64'(1) << e.idx);
        chk("wr_err", 64'(wr_err), 64'(e.err));
        chk("rf_en_w", 64'(rf_en_w), 64'(e.en));
        chk("rf_sel_w", 64'(rf_sel_w), 64'(e.sel));
        chk("rf_data_in", 64'(rf_data_in), 64'(e.data));
        chk("wr_cycle", 64'(cyc_n), 64'(e.cyc));
      end
    end
  end
  initial begin
    vals = '{16'h00A0, 16'h00B1, 16'h00C2, 16'h1234};
    rd_valid = '1;
    wr_valid = '1;
    tick();
    tick();
    chk("rst_rd_ready", 64'(rd_ready), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_outputs", 64'({rf_en_r, rf_en_w, rf_sel_r, rf_sel_w, rsp_valid, rsp_err, wr_ack, wr_err}), 64'(0));
    chk("rst_data", 64'({rf_data_in, rsp_data}), 64'(0));
    rd_valid = '0;
    wr_valid = '0;
    rst_n = 1'b1;
    tick();
    // Write 0x1234 to addr 3, then read it back through requester 2
    set_wr(0, 4'd3, 16'h1234);
    #1 chk("t1_wr_ready", 64'(wr_ready), 64'b0001);
    exp_wr(0, 1'b0, 1'b1, 4'd3, 16'h1234);
    tick();
    wr_valid = '0;
    set_rd(2, 4'd3);
    #1 chk("t1_rd_ready", 64'(rd_ready), 64'b0100);
    exp_rd(2, 16'h1234, 1'b0);
    tick();
    rd_valid = '0;
    set_wr(1, 4'd0, 16'h00A0);
    #1 chk("pre_wr1_ready", 64'(wr_ready), 64'b0010);
    exp_wr(1, 1'b0, 1'b1, 4'd0, 16'h00A0);
    tick();
    wr_valid = '0;
    set_wr(2, 4'd1, 16'h00B1);
    #1 chk("pre_wr2_ready", 64'(wr_ready), 64'b0100);
    exp_wr(2, 1'b0, 1'b1, 4'd1, 16'h00B1);
    tick();
    wr_valid = '0;
    set_wr(3, 4'd2, 16'h00C2);
    #1 chk("pre_wr3_ready", 64'(wr_ready), 64'b1000);
    exp_wr(3, 1'b0, 1'b1, 4'd2, 16'h00C2);
    tick();
    wr_valid = '0;
    set_rd(3, 4'd2);
    #1 chk("pre_rd3_ready", 64'(rd_ready), 64'b1000);
    exp_rd(3, 16'h00C2, 1'b0);
    tick();
    rd_valid = '0;
    tick();
    // All four readers requesting continuously: strict rotation, one response per cycle
    for (int i = 0; i < N; i++) set_rd(i, AW'(i));
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_rd_ready", 64'(rd_ready), 64'(1) << (k % 4));
      exp_rd(k % 4, vals[k % 4], 1'b0);
      tick();
    end
    rd_valid = '0;
    tick();
    tick();
    // Same-cycle write and read of addr 5 must return the new data
    set_wr(1, 4'd5, 16'hBEEF);
    set_rd(0, 4'd5);
    #1 chk("t3_wr_ready", 64'(wr_ready), 64'b0010);
    chk("t3_rd_ready", 64'(rd_ready), 64'b0001);
    exp_wr(1, 1'b0, 1'b1, 4'd5, 16'hBEEF);
    exp_rd(0, 16'hBEEF, 1'b0);
    tick();
    rd_valid = '0;
    wr_valid = '0;
    // Out-of-range read (9) and write (8): no enables, selects/data hold
    set_rd(1, 4'd9);
    set_wr(2, 4'd8, 16'h5555);
    #1 chk("t4_rd_ready", 64'(rd_ready), 64'b0010);
    chk("t4_wr_ready", 64'(wr_ready), 64'b0100);
    exp_rd(1, 16'h0000, 1'b1);
    exp_wr(2, 1'b1, 1'b0, 4'd5, 16'hBEEF);
    tick();
    rd_valid = '0;
    wr_valid = '0;
    chk("t4_rf_en_r", 64'(rf_en_r), 64'(0));
    chk("t4_rf_sel_r_hold", 64'(rf_sel_r), 64'(5));
    tick();
    tick();
    // Reset one cycle after a read is accepted: the response is cancelled
    set_rd(2, 4'd0);
    #1 chk("t5_rd_ready", 64'(rd_ready), 64'b0100);
    tick();
    rd_valid = '0;
    rst_n = 1'b0;
    chk("t5_rf_en_r_pre", 64'(rf_en_r), 64'(1));
    tick();
    chk("t5_rf_en_r_rst", 64'(rf_en_r), 64'(0));
    chk("t5_rsp_valid_rst", 64'(rsp_valid), 64'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_rd(i, AW'(i));
    for (int i = 0; i < N; i++) set_wr(i, 4'd6, 16'h0066);
    #1 chk("t5_rd_ptr_reset", 64'(rd_ready), 64'b0001);
    chk("t5_wr_ptr_reset", 64'(wr_ready), 64'b0001);
    exp_rd(0, 16'h00A0, 1'b0);
    exp_wr(0, 1'b0, 1'b1, 4'd6, 16'h0066);
    tick();
    rd_valid = '0;
    wr_valid = '0;
    for (int k = 0; k < 5; k++) tick();
    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
    chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
